// File: rtl/alu_packet_parser.sv
// Command packet framer between the UART RX byte stream and the ALU / echo paths.
// Packet: opcode, reserved, len[7:0], len[15:8], payload (len counts the header).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for the opcode byte
// ST_RSVD    | discarding the reserved byte
// ST_LEN_LO  | capturing length bits [7:0]
// ST_LEN_HI  | capturing length bits [15:8], validating the header
// ST_ECHO    | forwarding payload bytes to the echo path
// ST_OPERAND | packing payload into 32-bit little-endian operands
// ST_DRAIN   | discarding the payload of a rejected packet
module alu_packet_parser #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hA0,
  parameter logic [7:0] OP_MUL  = 8'hA1,
  parameter logic [7:0] OP_DIV  = 8'hA2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_op_data,
  output logic [7:0]  m_op_code,
  output logic        m_op_first,
  output logic        m_op_last,
  output logic        m_op_valid,
  input  logic        m_op_ready,
  output logic [7:0]  m_echo_tdata,
  output logic        m_echo_tlast,
  output logic        m_echo_tvalid,
  input  logic        m_echo_tready,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO, ST_OPERAND, ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic        first_pend_q, first_pend_d;
  logic [31:0] op_data_q, op_data_d;
  logic [7:0]  op_code_q, op_code_d;
  logic        op_first_q, op_first_d;
  logic        op_last_q, op_last_d;
  logic        op_valid_q, op_valid_d;
  logic [7:0]  echo_data_q, echo_data_d;
  logic        echo_last_q, echo_last_d;
  logic        echo_valid_q, echo_valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        rst_done_q, rst_done_d;

  logic        tready;
  logic        accept;
  logic [15:0] len_full;
  logic [15:0] len_rem;
  logic        is_echo, is_div, is_arith, is_known;

  assign len_full = {s_axis_tdata, len_lo_q};
  assign len_rem  = len_full - 16'd4;
  assign is_echo  = (opcode_q == OP_ECHO);
  assign is_div   = (opcode_q == OP_DIV);
  assign is_arith = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || is_div;
  assign is_known = is_echo || is_arith;

  // Input ready per state; held low until the first clock after reset release.
  always_comb begin
    tready = 1'b0;
    case (state_q)
      ST_ECHO:    tready = !echo_valid_q || m_echo_tready;
      ST_OPERAND: tready = !((lane_q == 2'd3) && op_valid_q && !m_op_ready);
      default:    tready = 1'b1;
    endcase
    tready = tready && rst_done_q;
  end

  assign accept = s_axis_tvalid && tready;

  // Next-state, datapath and output register updates.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_lo_d     = len_lo_q;
    remaining_d  = remaining_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    first_pend_d = first_pend_q;
    op_data_d    = op_data_q;
    op_code_d    = op_code_q;
    op_first_d   = op_first_q;
    op_last_d    = op_last_q;
    op_valid_d   = op_valid_q;
    echo_data_d  = echo_data_q;
    echo_last_d  = echo_last_q;
    echo_valid_d = echo_valid_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    rst_done_d   = 1'b1;

    // A completed handshake frees the slot; a reload below takes priority.
    if (op_valid_q && m_op_ready) op_valid_d = 1'b0;
    if (echo_valid_q && m_echo_tready) echo_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        opcode_d = s_axis_tdata;
        state_d  = ST_RSVD;
      end
      ST_RSVD: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: if (accept) begin
        len_lo_d = s_axis_tdata;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        op_code_d    = opcode_q;
        lane_d       = 2'd0;
        first_pend_d = 1'b1;
        remaining_d  = len_rem;
        if (!is_known) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          // A short header-only packet leaves nothing to drain.
          if (len_full <= 16'd4) begin
            remaining_d = 16'd0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (len_full < 16'd4) begin
          err_d       = 1'b1;
          err_code_d  = 2'd2;
          remaining_d = 16'd0;
          state_d     = ST_IDLE;
        end else if (is_arith && ((len_rem == 16'd0) || (len_rem[1:0] != 2'd0) ||
                                  (is_div && (len_full != 16'd12)))) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = (len_rem == 16'd0) ? ST_IDLE : ST_DRAIN;
        end else if (is_echo) begin
          state_d = (len_rem == 16'd0) ? ST_IDLE : ST_ECHO;
        end else begin
          state_d = ST_OPERAND;
        end
      end
      ST_ECHO: if (accept) begin
        echo_data_d  = s_axis_tdata;
        echo_valid_d = 1'b1;
        echo_last_d  = (remaining_q == 16'd1);
        remaining_d  = remaining_q - 16'd1;
        if (remaining_q == 16'd1) state_d = ST_IDLE;
      end
      ST_OPERAND: if (accept) begin
        lane_d = lane_q + 2'd1;
        case (lane_q)
          2'd0: acc_d[7:0]   = s_axis_tdata;
          2'd1: acc_d[15:8]  = s_axis_tdata;
          2'd2: acc_d[23:16] = s_axis_tdata;
          default: begin
            op_data_d    = {s_axis_tdata, acc_q};
            op_valid_d   = 1'b1;
            op_first_d   = first_pend_q;
            op_last_d    = (remaining_q == 16'd4);
            first_pend_d = 1'b0;
            remaining_d  = remaining_q - 16'd4;
            if (remaining_q == 16'd4) state_d = ST_IDLE;
          end
        endcase
      end
      ST_DRAIN: if (accept) begin
        remaining_d = remaining_q - 16'd1;
        if (remaining_q == 16'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      opcode_q     <= 8'd0;
      len_lo_q     <= 8'd0;
      remaining_q  <= 16'd0;
      lane_q       <= 2'd0;
      acc_q        <= 24'd0;
      first_pend_q <= 1'b0;
      op_data_q    <= 32'd0;
      op_code_q    <= 8'd0;
      op_first_q   <= 1'b0;
      op_last_q    <= 1'b0;
      op_valid_q   <= 1'b0;
      echo_data_q  <= 8'd0;
      echo_last_q  <= 1'b0;
      echo_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_lo_q     <= len_lo_d;
      remaining_q  <= remaining_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      first_pend_q <= first_pend_d;
      op_data_q    <= op_data_d;
      op_code_q    <= op_code_d;
      op_first_q   <= op_first_d;
      op_last_q    <= op_last_d;
      op_valid_q   <= op_valid_d;
      echo_data_q  <= echo_data_d;
      echo_last_q  <= echo_last_d;
      echo_valid_q <= echo_valid_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      rst_done_q   <= rst_done_d;
    end
  end

  assign s_axis_tready = tready;
  assign m_op_data     = op_data_q;
  assign m_op_code     = op_code_q;
  assign m_op_first    = op_first_q;
  assign m_op_last     = op_last_q;
  assign m_op_valid    = op_valid_q;
  assign m_echo_tdata  = echo_data_q;
  assign m_echo_tlast  = echo_last_q;
  assign m_echo_tvalid = echo_valid_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Scoreboard bench for alu_packet_parser: packets are modelled at packet level,
// expectations queued, and a monitor pops them as the DUT hands data off.
module tb_alu_packet_parser;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_op_data;
  logic [7:0]  m_op_code;
  logic        m_op_first, m_op_last, m_op_valid;
  logic        m_op_ready = 1'b1;
  logic [7:0]  m_echo_tdata;
  logic        m_echo_tlast, m_echo_tvalid;
  logic        m_echo_tready = 1'b1;
  logic        err_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  alu_packet_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
    .m_op_data(m_op_data), .m_op_code(m_op_code), .m_op_first(m_op_first),
    .m_op_last(m_op_last), .m_op_valid(m_op_valid), .m_op_ready(m_op_ready),
    .m_echo_tdata(m_echo_tdata), .m_echo_tlast(m_echo_tlast),
    .m_echo_tvalid(m_echo_tvalid), .m_echo_tready(m_echo_tready),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  typedef struct packed { logic [31:0] d; logic [7:0] c; logic f; logic l; } op_t;
  typedef struct packed { logic [7:0] d; logic l; } echo_t;

  op_t        exp_op[$];
  echo_t      exp_echo[$];
  logic [1:0] exp_err[$];

  int total = 0;
  int bad   = 0;

  bit rnd_ready = 1'b0;
  bit rnd_gap   = 1'b0;
  int stall_op  = 0;
  bit saw_block = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: decide the packet's fate and queue what must appear.
  task automatic model_packet(input logic [7:0] p[$]);
    logic [7:0] op;
    int len, rem;
    bit known, arith;
    op    = p[0];
    len   = int'({p[3], p[2]});
    rem   = len - 4;
    arith = (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    known = arith || (op == OP_ECHO);
    if (!known) exp_err.push_back(2'd1);
    else if (len < 4) exp_err.push_back(2'd2);
    else if (arith && (rem == 0 || rem % 4 != 0 || (op == OP_DIV && len != 12)))
      exp_err.push_back(2'd2);
    else if (op == OP_ECHO) begin
      for (int i = 0; i < rem; i++) exp_echo.push_back('{d: p[4+i], l: (i == rem - 1)});
    end else begin
      for (int k = 0; k < rem / 4; k++) begin
        op_t o;
        o.d = {p[7+4*k], p[6+4*k], p[5+4*k], p[4+4*k]};
        o.c = op;
        o.f = (k == 0);
        o.l = (k == rem / 4 - 1);
        exp_op.push_back(o);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit rdy, done;
    if (rnd_gap && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      s_tvalid = 1'b0;
    end
    @(negedge clk);
    s_tdata  = b;
    s_tvalid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 500; n++) begin
      #4;
      rdy = s_axis_tready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout actual=stuck required=accepted byte=%h", b);
    end
  endtask

  task automatic send_raw(input logic [7:0] p[$]);
    foreach (p[i]) send_byte(p[i]);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] p[$]);
    model_packet(p);
    send_raw(p);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_op.size() != 0 || exp_echo.size() != 0 || exp_err.size() != 0 ||
            m_op_valid || m_echo_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_timeout actual=op%0d/echo%0d/err%0d pending required=0",
               exp_op.size(), exp_echo.size(), exp_err.size());
    end
  endtask

  task automatic rand_packet();
    logic [7:0] p[$];
    logic [7:0] op;
    logic [15:0] len16;
    int len;
    int kind;
    kind = $urandom_range(0, 5);
    op  = OP_ECHO;
    len = 4;
    case (kind)
      0: begin op = OP_ECHO; len = $urandom_range(4, 24); end
      1: begin op = OP_ADD;  len = 4 + 4 * $urandom_range(1, 4); end
      2: begin op = OP_MUL;  len = 4 + 4 * $urandom_range(1, 4); end
      3: begin op = OP_DIV;  len = 12; end
      4: begin
        do op = 8'($urandom); while (op == OP_ECHO || op == OP_ADD || op == OP_MUL || op == OP_DIV);
        len = $urandom_range(0, 10);
      end
      default: begin
        op = OP_ADD + 8'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0: len = $urandom_range(0, 3);
          1: len = 4 + 4 * $urandom_range(0, 3) + $urandom_range(1, 3);
          2: len = 4;
          default: begin op = OP_DIV; len = 16; end
        endcase
      end
    endcase
    len16 = 16'(len);
    p.push_back(op);
    p.push_back(8'($urandom));
    p.push_back(len16[7:0]);
    p.push_back(len16[15:8]);
    for (int i = 4; i < len; i++) p.push_back(8'($urandom));
    send_packet(p);
  endtask

  // Monitor: drives the sink readies, then checks handshakes just before each rising edge.
  initial begin : monitor
    bit op_stalled, echo_stalled;
    logic [31:0] op_held;
    logic [7:0]  echo_held;
    op_stalled   = 1'b0;
    echo_stalled = 1'b0;
    op_held      = 32'd0;
    echo_held    = 8'd0;
    forever begin
      @(negedge clk);
      if (stall_op > 0 && m_op_valid) begin
        m_op_ready = 1'b0;
        stall_op--;
      end else begin
        m_op_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      m_echo_tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #4;
      if (!rst) begin
        op_stalled   = 1'b0;
        echo_stalled = 1'b0;
      end else begin
        if (s_tvalid && !s_axis_tready && m_op_valid && !m_op_ready) saw_block = 1'b1;
        if (op_stalled) begin
          chk("op_hold_valid", 32'(m_op_valid), 32'd1);
          chk("op_hold_data", m_op_data, op_held);
        end
        if (echo_stalled) begin
          chk("echo_hold_valid", 32'(m_echo_tvalid), 32'd1);
          chk("echo_hold_data", 32'(m_echo_tdata), 32'(echo_held));
        end
        if (m_op_valid && m_op_ready) begin
          if (exp_op.size() == 0) chk("op_unexpected", 32'(m_op_data), 32'hxxxxxxxx);
          else begin
            op_t e;
            e = exp_op.pop_front();
            chk("op_data", m_op_data, e.d);
            chk("op_code", 32'(m_op_code), 32'(e.c));
            chk("op_first", 32'(m_op_first), 32'(e.f));
            chk("op_last", 32'(m_op_last), 32'(e.l));
          end
        end
        if (m_echo_tvalid && m_echo_tready) begin
          if (exp_echo.size() == 0) chk("echo_unexpected", 32'(m_echo_tdata), 32'hxxxxxxxx);
          else begin
            echo_t e;
            e = exp_echo.pop_front();
            chk("echo_data", 32'(m_echo_tdata), 32'(e.d));
            chk("echo_last", 32'(m_echo_tlast), 32'(e.l));
          end
        end
        if (err_o) begin
          if (exp_err.size() == 0) chk("err_unexpected", 32'(err_code_o), 32'hxxxxxxxx);
          else chk("err_code", 32'(err_code_o), 32'(exp_err.pop_front()));
        end
        op_stalled   = m_op_valid && !m_op_ready;
        op_held      = m_op_data;
        echo_stalled = m_echo_tvalid && !m_echo_tready;
        echo_held    = m_echo_tdata;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_op_valid"}, 32'(m_op_valid), 32'd0);
    chk({tag, "_echo_valid"}, 32'(m_echo_tvalid), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_op_data"}, m_op_data, 32'd0);
    chk({tag, "_op_code"}, 32'(m_op_code), 32'd0);
    chk({tag, "_op_fl"}, 32'({m_op_first, m_op_last}), 32'd0);
    chk({tag, "_echo_data"}, 32'({m_echo_tdata, m_echo_tlast}), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code_o), 32'd0);
  endtask

  initial begin : stimulus
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Echo of three bytes.
    send_packet('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
    wait_empty();

    // Two-operand add.
    send_packet('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF});
    wait_empty();

    // Same add with the ALU stalled for 10 cycles after the first operand.
    saw_block = 1'b0;
    stall_op  = 10;
    send_packet('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF});
    wait_empty();
    chk("backpressure_tready_low", 32'(saw_block), 32'd1);
    chk("backpressure_stall_used", 32'(stall_op), 32'd0);

    // Unknown opcode with payload drained, then a one-byte echo.
    send_packet('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
    send_packet('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    wait_empty();
    chk("bad_op_code_held", 32'(err_code_o), 32'd1);

    // DIV with len=16 drained; add with len=2 rejected at the header.
    send_packet('{8'hA2, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C});
    send_packet('{8'hA0, 8'h00, 8'h02, 8'h00});
    send_packet('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22});
    wait_empty();
    chk("bad_len_code_held", 32'(err_code_o), 32'd2);

    // Empty echo, then a 260-byte echo so the length high byte matters.
    begin
      logic [7:0] p[$];
      send_packet('{8'hEC, 8'h00, 8'h04, 8'h00});
      p = '{8'hEC, 8'h00, 8'h08, 8'h01};
      for (int i = 0; i < 260; i++) p.push_back(8'(i * 7 + 3));
      send_packet(p);
      wait_empty();
    end

    // Reset in the middle of an add packet.
    send_raw('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00});
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    send_packet('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h77, 8'h88});
    wait_empty();

    // Randomized packets with random sink readiness and source gaps.
    rnd_ready = 1'b1;
    rnd_gap   = 1'b1;
    for (int n = 0; n < 60; n++) rand_packet();
    wait_empty();
    chk("final_op_queue", 32'(exp_op.size()), 32'd0);
    chk("final_echo_queue", 32'(exp_echo.size()), 32'd0);
    chk("final_err_queue", 32'(exp_err.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_packet_parser.md
Name: alu_packet_parser

Overview:
- Sits inside top, directly downstream of the UART receiver's AXI-stream byte output (m_axis_* of the uart instance).
- Frames the incoming byte stream into command packets: opcode, reserved byte, 16-bit little-endian total length, then payload.
- Echo payload is forwarded byte-wise to the echo path. Arithmetic payload is assembled into 32-bit little-endian operands and handed to the ALU datapath.
- Malformed packets are drained and flagged.

Parameters:
- OP_ECHO, 8'hEC, echo opcode
- OP_ADD, 8'hA0, add32 opcode
- OP_MUL, 8'hA1, mul32 opcode
- OP_DIV, 8'hA2, div32 opcode (exactly two operands)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- s_axis_tdata  in  8  byte from UART RX
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  parser accepts byte
- m_op_data  out  32  assembled operand
- m_op_code  out  8  opcode of current packet
- m_op_first  out  1  operand is first of packet
- m_op_last  out  1  operand is last of packet
- m_op_valid  out  1  operand valid
- m_op_ready  in  1  ALU accepts operand
- m_echo_tdata  out  8  echo byte
- m_echo_tlast  out  1  last echo byte of packet
- m_echo_tvalid  out  1  echo byte valid
- m_echo_tready  in  1  echo sink accepts
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  latched cause: 0 none, 1 bad opcode, 2 bad length

Behaviour:
- Reset (rst=0, async): state IDLE; all valids, err_o, m_op_first, m_op_last, m_echo_tlast = 0; m_op_data, m_op_code, m_echo_tdata, err_code_o = 0; byte counters = 0. s_axis_tready = 0 while rst=0.
- Byte accept: a byte transfers when s_axis_tvalid & s_axis_tready at posedge clk.
- States and transitions:
  - IDLE: latch opcode → RSVD.
  - RSVD: discard byte → LEN_LO.
  - LEN_LO: latch len[7:0] → LEN_HI.
  - LEN_HI: latch len[15:8], set remaining = len - 4, then check:
    - opcode not one of the four: err_code=1, err_o pulse → DRAIN (or IDLE if remaining=0).
    - len < 4: err_code=2, err_o pulse → IDLE.
    - arithmetic with remaining=0 or remaining[1:0]≠0, or DIV with len≠12: err_code=2, err_o pulse → DRAIN (or IDLE if remaining=0).
    - ECHO with remaining=0: → IDLE, no output.
    - otherwise → ECHO or OPERAND.
  - ECHO: each accepted byte loads the echo register and decrements remaining. tlast is set when remaining=1 at accept. After the last byte → IDLE.
  - OPERAND: lane counter 0..3. Byte k goes to bits [8k+7:8k]. On lane 3, load m_op_data, set m_op_valid, and decrement remaining by 4 (decrement-per-byte is also acceptable). m_op_first is set for the first operand of the packet; m_op_last is set when this is the final 4 bytes. After the last operand → IDLE.
  - DRAIN: accept and discard bytes until remaining=0 → IDLE.
- Handshake / backpressure:
  - Output registers are single-entry.
  - In ECHO: s_axis_tready = !m_echo_tvalid | m_echo_tready.
  - In OPERAND: s_axis_tready = 0 only when lane=3 and m_op_valid & !m_op_ready; otherwise 1. Bytes for lanes 0–2 may be accepted while the previous operand is still pending.
  - Valid clears on a ready handshake unless it is reloaded in the same cycle.
  - Valid/data are stable while valid & !ready.
  - In IDLE/RSVD/LEN_LO/LEN_HI/DRAIN: s_axis_tready = 1.
- m_op_code holds the latched opcode from LEN_HI until the next packet's LEN_HI.
- err_code_o holds until the next error; a good packet does not clear it.
- Length field is unsigned 16-bit; len=16'hFFFF is legal for ECHO (65531 payload bytes); the counter must not wrap.
- Latency: byte accepted → echo valid next cycle; 4th operand byte accepted → m_op_valid next cycle.
- Reset mid-packet discards all partial state; the next byte after reset is treated as an opcode.

Test Plan:
- Echo: EC 00 07 00 41 42 43, ready=1 → echo bytes 41,42,43 on consecutive cycles, tlast only on 43, err_o never 1.
- Add two operands: A0 00 0C 00 01 00 00 00 FF FF FF FF → m_op_data 00000001 (first=1, last=0), then FFFFFFFF (first=0, last=1), m_op_code=A0.
- Backpressure: same ADD packet with m_op_ready held 0 for 10 cycles after first valid → m_op_data stays 00000001; s_axis_tready drops at lane 3 of operand 2; no byte is lost after ready rises.
- Bad opcode: 55 00 06 00 AA BB, then EC 00 05 00 5A → err_o pulses once, err_code_o=1, AA/BB dropped, then echo emits 5A with tlast.
- Bad length: A2 00 10 00 + 12 bytes (DIV with len=16) → err_code_o=2, no m_op_valid, 12 bytes drained, parser back in IDLE. Also A0 00 02 00 → err immediately, next byte is parsed as an opcode.
- Reset mid-packet: assert rst=0 after byte 6 of an ADD packet → all outputs 0 immediately. After release, a new echo packet is parsed correctly.
